elixirchip_es1_spu_op_match_index: RTL
======================================

// Module: elixirchip_es1_spu_op_match_index
//
// PURPOSE
//  Consumer end of the spu_op_match flag stream.
//  - Takes a windowed stream of 1-bit match flags. A window is a run of accepted samples ended by s_last.
//  - Per window, reports: whether any match occurred, the index of the first match, and the match count.
//  - Sits directly downstream of spu_op_match (s_match <= m_data). Gives SPU programs a search/find primitive.
//
// PARAMETERS
//  INDEX_BITS   8                  width of sample index; max window = 2**INDEX_BITS samples
//  COUNT_BITS   INDEX_BITS+1       width of match counter (holds 0 .. 2**INDEX_BITS)
//  CLEAR_INDEX  '0                 m_index value when nothing was found
//  DEVICE       "RTL"              target device ("RTL", "ULTRASCALE_PLUS")
//  SIMULATION   "false"            simulation-only checks enabled
//  DEBUG        "false"            debug attributes on internal regs
//
// PORTS
//  clk          in   1           clock
//  reset        in   1           synchronous reset, active-high
//  cke          in   1           clock enable; all state holds when 0
//  s_match      in   1           match flag of current sample
//  s_last       in   1           current sample closes the window
//  s_clear      in   1           abort current window
//  s_valid      in   1           sample valid
//  m_found      out  1           >=1 match in the closed window
//  m_index      out  INDEX_BITS  index of first match (0-based), else CLEAR_INDEX
//  m_count      out  COUNT_BITS  number of matches in the window
//  m_overflow   out  1           window exceeded 2**INDEX_BITS samples
//  m_valid      out  1           result strobe, one cke-cycle per closed window
//
// BEHAVIOUR
//  - Accept: a sample is accepted when cke && s_valid. Nothing advances when cke=0, including m_* (all held).
//  - States:
//    IDLE  -> pos=0, no sample taken yet
//    SCAN  -> >=1 sample taken, no match yet
//    FOUND -> first match captured
//  - Transitions on an accepted sample:
//    IDLE/SCAN with s_match=1 -> FOUND; first_idx <= pos
//    IDLE with s_match=0      -> SCAN
//    Any state with s_last=1  -> IDLE (after the sample is counted)
//  - pos increments per accepted sample.
//    - At pos = 2**INDEX_BITS-1 (last legal index), pos saturates and ovf sets; ovf is sticky until the window closes.
//    - Samples beyond the limit: still counted in cnt, but never captured as first index.
//  - cnt increments per accepted sample with s_match=1; saturates at 2**INDEX_BITS.
//  - Latency 1: for the s_last sample, the m_* values are registered on that edge and m_valid=1 for one cke-cycle.
//    The s_last sample's own match is included.
//  - m_valid returns to 0 at the next cke edge unless another window closes on that edge.
//  - Back-to-back windows are allowed. A single-sample window (s_last on the first sample) is legal.
//  - s_clear (qualified by cke, regardless of s_valid):
//    - Discards the window, goes to IDLE, and produces no m_valid.
//    - s_clear && s_last in the same sample: clear wins, no result.
//  - m_* outputs other than m_valid hold the last result until the next closed window.
//  - reset (synchronous, any time, including mid-window):
//    - State -> IDLE; pos, cnt, ovf <= 0.
//    - m_found=0, m_index=CLEAR_INDEX, m_count=0, m_overflow=0, m_valid=0.
//  - Not found: m_found=0, m_index=CLEAR_INDEX, m_count=0.
//  - SIMULATION="true": assert that s_match/s_last are never X when s_valid=1 and cke=1.
//
// CONFIGURATION
//  ELIXIRCHIP_ES1_SPU_OP_MATCH_INDEX_LAST_EN
//  - Defined: adds output m_last_index [INDEX_BITS], the index of the last match in the window.
//    - Updated alongside m_index.
//    - CLEAR_INDEX when nothing was found.
//    - Same reset and overflow rules as m_index.
//  - Undefined: port and logic absent; all other behaviour identical.
//
// TESTING  (INDEX_BITS=8 unless noted)
//  1. Window s_match = 0,0,1,0,1, with s_last on sample 4
//     -> m_valid pulse 1 cycle after; m_found=1, m_index=2, m_count=2, m_overflow=0 (m_last_index=4 when _EN).
//  2. Window of 6 zeros; cke=0 inserted for 3 cycles mid-window
//     -> m_found=0, m_index=CLEAR_INDEX, m_count=0; m_valid held during cke=0 stalls.
//  3. Windows back-to-back: {1 with s_last}, then {0,1 with s_last}
//     -> two consecutive m_valid pulses; results (1,0,1) then (1,1,1).
//  4. s_clear on sample 2 of window 1,1,1; then new window 0,1 with s_last
//     -> no m_valid for the aborted window; next result m_index=1, m_count=1.
//  5. INDEX_BITS=2, window of 6 samples with s_match=1 only on samples 1 and 5, s_last on 5
//     -> m_overflow=1, m_index=1, m_count=2.
//  6. Assert reset mid-window after 3 matches, then window 0,0,1 with s_last
//     -> all outputs 0/CLEAR_INDEX during reset; result m_index=2, m_count=1.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_match_index.sv
// Per-window first-match index, match count and overflow reporter for the spu_op_match flag stream.
// Optional m_last_index output is enabled with `define ELIXIRCHIP_ES1_SPU_OP_MATCH_INDEX_LAST_EN.
module elixirchip_es1_spu_op_match_index #(
    parameter int                    INDEX_BITS  = 8,
    parameter int                    COUNT_BITS  = INDEX_BITS + 1,
    parameter logic [INDEX_BITS-1:0] CLEAR_INDEX = '0,
    parameter string                 DEVICE      = "RTL",
    parameter string                 SIMULATION  = "false",
    parameter string                 DEBUG       = "false"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic                  s_match,
    input  logic                  s_last,
    input  logic                  s_clear,
    input  logic                  s_valid,
    output logic                  m_found,
    output logic [INDEX_BITS-1:0] m_index,
`ifdef ELIXIRCHIP_ES1_SPU_OP_MATCH_INDEX_LAST_EN
    output logic [INDEX_BITS-1:0] m_last_index,
`endif
    output logic [COUNT_BITS-1:0] m_count,
    output logic                  m_overflow,
    output logic                  m_valid
);

    localparam logic [INDEX_BITS-1:0] POS_MAX = '1;
    localparam logic [COUNT_BITS-1:0] CNT_MAX = COUNT_BITS'(1) << INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FOUND = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [INDEX_BITS-1:0]   pos_reg;
    logic                    full_reg;
    logic                    ovf_reg;
    logic [COUNT_BITS-1:0]   cnt_reg;
    logic [INDEX_BITS-1:0]   first_reg;

    logic                    accept;
    logic                    abort;
    logic                    close;
    logic                    take_match;
    logic                    take_first;
    logic                    have_first;
    logic [COUNT_BITS-1:0]   win_cnt;
    logic [INDEX_BITS-1:0]   win_first;
    logic                    win_ovf;

    // Clear takes priority over a sample arriving in the same cycle.
    assign abort      = cke & s_clear;
    assign accept     = cke & s_valid & ~s_clear;
    assign close      = accept & s_last;
    // full_reg means the top index is already used; later samples lie past the window limit.
    assign take_match = accept & s_match & ~full_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else if (accept) begin
            if (s_last) begin
                state_next = ST_IDLE;
            end else if (take_match) begin
                state_next = ST_FOUND;
            end else if (state_reg == ST_IDLE) begin
                state_next = ST_SCAN;
            end
        end
    end

    always_comb begin
        have_first = (state_reg == ST_FOUND);
        take_first = take_match & (state_reg != ST_FOUND);
    end

    // Window summary including the sample presented this cycle.
    always_comb begin
        win_cnt = cnt_reg;
        if (s_match && (cnt_reg != CNT_MAX)) begin
            win_cnt = cnt_reg + COUNT_BITS'(1);
        end
        if (have_first) begin
            win_first = first_reg;
        end else if (take_first) begin
            win_first = pos_reg;
        end else begin
            win_first = CLEAR_INDEX;
        end
        win_ovf = ovf_reg | full_reg;
    end

    always_ff @(posedge clk) begin
        if (reset || (cke && (s_clear || close))) begin
            pos_reg   <= '0;
            full_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            first_reg <= CLEAR_INDEX;
        end else if (accept) begin
            if (pos_reg == POS_MAX) begin
                full_reg <= 1'b1;
            end else begin
                pos_reg <= pos_reg + INDEX_BITS'(1);
            end
            ovf_reg   <= win_ovf;
            cnt_reg   <= win_cnt;
            first_reg <= win_first;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_found    <= 1'b0;
            m_index    <= CLEAR_INDEX;
            m_count    <= '0;
            m_overflow <= 1'b0;
            m_valid    <= 1'b0;
        end else if (cke) begin
            m_valid <= close;
            if (close) begin
                m_found    <= (win_cnt != '0);
                m_index    <= win_first;
                m_count    <= win_cnt;
                m_overflow <= win_ovf;
            end
        end
    end

`ifdef ELIXIRCHIP_ES1_SPU_OP_MATCH_INDEX_LAST_EN
    logic [INDEX_BITS-1:0] last_reg;
    logic [INDEX_BITS-1:0] win_last;

    always_comb begin
        if (take_match) begin
            win_last = pos_reg;
        end else if (have_first) begin
            win_last = last_reg;
        end else begin
            win_last = CLEAR_INDEX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (cke && (s_clear || close))) begin
            last_reg <= CLEAR_INDEX;
        end else if (accept) begin
            last_reg <= win_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_last_index <= CLEAR_INDEX;
        end else if (close) begin
            m_last_index <= win_last;
        end
    end
`endif

    generate
        if (SIMULATION == "true") begin : g_sim_checks
            always @(posedge clk) begin
                if (!reset && cke && s_valid) begin
                    assert (!$isunknown({s_match, s_last}))
                    else $error("s_match/s_last unknown on an accepted sample");
                end
            end
        end
        if ((DEVICE != "RTL") && (DEVICE != "ULTRASCALE_PLUS")) begin : g_bad_device
            $error("unsupported DEVICE value");
        end
        if ((DEBUG != "true") && (DEBUG != "false")) begin : g_bad_debug
            $error("DEBUG must be \"true\" or \"false\"");
        end
    endgenerate

endmodule
